// File: rtl/seq_det_pkg.sv
// Shared types and reset-time configuration for the serial pattern-detection controller.
package seq_det_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [7:0] DEF_PATTERN = 8'h0F;
  localparam logic [3:0] DEF_LEN     = 4'd4;
  localparam logic       DEF_OVERLAP = 1'b0;

endpackage

// File: rtl/seq_match_core.sv
// Mealy pattern-match core: bit history, fill tracking and length-masked compare.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_vld,
  input  logic               data_bit,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [3:0]         len,
  input  logic               overlap,
  input  logic               flush,
  output logic               match
);

  localparam int FW = $clog2(PAT_MAX + 1);

  logic [PAT_MAX-1:0] hist;
  logic [PAT_MAX-1:0] hist_next;
  logic [PAT_MAX-1:0] mask;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_next;

  assign hist_next = {hist[PAT_MAX-2:0], data_bit};
  assign fill_next = (int'(fill) == PAT_MAX) ? fill : fill + 1'b1;
  assign mask      = ~({PAT_MAX{1'b1}} << len);

  // Decision is made on the history/fill as they will be after this bit lands.
  assign match = bit_vld && (int'(fill_next) >= int'(len)) &&
                 (((hist_next ^ pattern) & mask) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (flush) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_vld) begin
      hist <= hist_next;
      fill <= (match && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-bit serializer with handshake, runtime config checking and a saturating match counter.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               clr_cnt,
  output logic               z,
  output logic               busy,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int IW = $clog2(WORD_W);
  localparam logic [IW-1:0] LAST     = IW'(WORD_W - 1);
  localparam logic [IW-1:0] PRE_LAST = IW'(WORD_W - 2);

  state_t             state;
  logic [IW-1:0]      idx;
  logic [WORD_W-1:0]  word;
  logic [PAT_MAX-1:0] pattern;
  logic [3:0]         len;
  logic               overlap;
  logic               hs;
  logic               len_ok;
  logic               cfg_ok;
  logic               bit_vld;
  logic               match;

  assign hs      = in_valid && in_ready;
  assign len_ok  = (cfg_len != 4'd0) && (int'(cfg_len) <= PAT_MAX);
  assign cfg_ok  = cfg_we && (state == IDLE) && !hs && len_ok;
  assign bit_vld = (state == SHIFT);

  // in_ready is registered but reopens during the last bit so words stream gaplessly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            state    <= SHIFT;
            idx      <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        SHIFT: begin
          if (idx != LAST) begin
            idx      <= idx + 1'b1;
            in_ready <= (idx == PRE_LAST);
          end else if (hs) begin
            idx      <= '0;
            in_ready <= 1'b0;
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (hs)           word <= in_data;
    else if (bit_vld) word <= word << 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern <= PAT_MAX'(DEF_PATTERN);
      len     <= DEF_LEN;
      overlap <= DEF_OVERLAP;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
      end
    end
  end

  seq_match_core #(.PAT_MAX(PAT_MAX)) u_core (
    .clk      (clk),
    .rst      (rst),
    .bit_vld  (bit_vld),
    .data_bit (word[WORD_W-1]),
    .pattern  (pattern),
    .len      (len),
    .overlap  (overlap),
    .flush    (cfg_ok),
    .match    (match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z         <= 1'b0;
      match_cnt <= '0;
    end else begin
      z <= match;
      if (clr_cnt)                      match_cnt <= '0;
      else if (match && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a bit-queue reference model checked every cycle.
module tb_seq_det_ctrl;

  localparam int WORD_W  = 8;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_we = 1'b0;
  logic [PAT_MAX-1:0] cfg_pattern = '0;
  logic [3:0]         cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cfg_err;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data = '0;
  logic               clr_cnt = 1'b0;
  logic               z;
  logic               busy;
  logic [CNT_W-1:0]   match_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .clr_cnt(clr_cnt), .z(z), .busy(busy), .match_cnt(match_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: pending bits queue, newest-first history queue, fill, counter.
  int m_pat, m_len, fill, cnt, cyc, acc_cyc;
  bit m_ovl, m_z, m_err, idle, hs, mt;
  int pend[$];
  int hist[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete(); hist.delete();
      fill = 0; cnt = 0; m_z = 0; m_err = 0;
      m_pat = 15; m_len = 4; m_ovl = 0;
    end else begin
      cyc++;
      idle = (pend.size() == 0);
      hs   = in_valid && (pend.size() <= 1);
      mt   = 0;
      if (!idle) begin
        hist.push_front(pend.pop_front());
        if (hist.size() > PAT_MAX) void'(hist.pop_back());
        if (fill < PAT_MAX) fill++;
        if (fill >= m_len) begin
          mt = 1;
          for (int i = 0; i < m_len; i++)
            if (hist[i] != ((m_pat >> i) & 1)) mt = 0;
        end
        if (mt && !m_ovl) fill = 0;
      end
      if (hs) begin
        acc_cyc = cyc;
        for (int i = WORD_W - 1; i >= 0; i--) pend.push_back(int'(in_data[i]));
      end
      m_err = 0;
      if (cfg_we) begin
        if (idle && !hs && cfg_len >= 1 && cfg_len <= PAT_MAX) begin
          m_pat = int'(cfg_pattern); m_len = int'(cfg_len); m_ovl = cfg_overlap;
          hist.delete(); fill = 0;
        end else m_err = 1;
      end
      if (clr_cnt) cnt = 0;
      else if (mt && cnt < CNT_MAX) cnt++;
      m_z = mt;
    end
  end

  int zlog[$];
  int busy_cnt;

  always @(negedge clk) begin
    chk("z", int'(z), int'(m_z));
    chk("busy", int'(busy), int'(pend.size() > 0));
    chk("in_ready", int'(in_ready), int'(pend.size() <= 1));
    chk("cfg_err", int'(cfg_err), int'(m_err));
    chk("match_cnt", int'(match_cnt), cnt);
    if (z) zlog.push_back(cyc);
    if (busy) busy_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [WORD_W-1:0] d);
    bit done = 0;
    in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 40 && !done; i++) begin
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!busy) done = 1;
      else tick();
    end
    if (!done) chk("idle_timeout", 0, 1);
    tick(); tick();
  endtask

  task automatic cfg(input int pat, input int len, input bit ovl);
    cfg_pattern = PAT_MAX'(pat); cfg_len = 4'(len); cfg_overlap = ovl;
    cfg_we = 1'b1; tick(); cfg_we = 1'b0;
  endtask

  task automatic clr();
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    zlog.delete(); busy_cnt = 0;
  endtask

  int t0, t1;

  initial begin
    tick(); tick();
    chk("rst_z", int'(z), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_cnt", int'(match_cnt), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    rst = 1'b1; tick();

    // Default config, single 0xFF
    clr();
    send(8'hFF); t0 = acc_cyc;
    wait_idle();
    chk("t1_cnt", int'(match_cnt), 2);
    chk("t1_npulse", zlog.size(), 2);
    if (zlog.size() == 2) begin
      chk("t1_z0", zlog[0] - t0, 4);
      chk("t1_z1", zlog[1] - t0, 8);
    end
    chk("t1_busy", busy_cnt, 8);

    // Overlap mode, 0xFF
    cfg(8'h0F, 4, 1'b1); clr();
    send(8'hFF); t0 = acc_cyc;
    wait_idle();
    chk("t2_cnt", int'(match_cnt), 5);
    chk("t2_npulse", zlog.size(), 5);
    if (zlog.size() == 5) begin
      chk("t2_zfirst", zlog[0] - t0, 4);
      chk("t2_zlast", zlog[4] - t0, 8);
    end

    // Pattern 101, len 3, overlap, 0xAA
    cfg(8'h05, 3, 1'b1); clr();
    send(8'hAA); t0 = acc_cyc;
    wait_idle();
    chk("t3_cnt", int'(match_cnt), 3);
    chk("t3_npulse", zlog.size(), 3);
    if (zlog.size() == 3) begin
      chk("t3_z0", zlog[0] - t0, 3);
      chk("t3_z1", zlog[1] - t0, 5);
      chk("t3_z2", zlog[2] - t0, 7);
    end

    // Back-to-back 0x0F, 0xF0 under default config
    cfg(8'h0F, 4, 1'b0); clr();
    send(8'h0F); t0 = acc_cyc;
    send(8'hF0); t1 = acc_cyc;
    wait_idle();
    chk("t4_accept_gap", t1 - t0, 8);
    chk("t4_busy", busy_cnt, 16);
    chk("t4_npulse", zlog.size(), 2);
    if (zlog.size() == 2) begin
      chk("t4_z0", zlog[0] - t0, 8);
      chk("t4_z1", zlog[1] - t0, 12);
    end

    // Rejected config writes
    clr();
    send(8'hFF);
    cfg(8'h00, 2, 1'b1);
    chk("t5_err_busy", int'(cfg_err), 1);
    wait_idle();
    cfg(8'h03, 0, 1'b1);
    chk("t5_err_len0", int'(cfg_err), 1);
    tick();
    chk("t5_err_clear", int'(cfg_err), 0);
    clr();
    send(8'hFF);
    wait_idle();
    chk("t5_cnt", int'(match_cnt), 2);

    // Reset mid-word
    zlog.delete();
    send(8'hFF);
    tick(); tick();
    rst = 1'b0; #1;
    chk("t6_z", int'(z), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_in_ready", int'(in_ready), 1);
    chk("t6_cnt", int'(match_cnt), 0);
    tick(); rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_no_z", zlog.size(), 0);

    // Counter saturation and clear priority
    cfg(8'h01, 1, 1'b1); clr();
    for (int i = 0; i < 32; i++) send(8'hFF);
    wait_idle();
    chk("t7_sat", int'(match_cnt), CNT_MAX);
    send(8'hFF);
    wait_idle();
    chk("t7_sat_hold", int'(match_cnt), CNT_MAX);
    send(8'hFF);
    tick();
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    chk("t7_clr_prio", int'(match_cnt), 0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable serial pattern-detection controller. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first, one bit per clock, into a Mealy pattern-match core. It raises a registered one-cycle match pulse and maintains a saturating match counter. Pattern, length and overlap mode are runtime-configurable, and the block sits between a word-oriented producer and the detection datapath.

## Interface
- WORD_W, 8, bits per input word
- PAT_MAX, 8, maximum pattern length in bits
- CNT_W, 16, match counter width

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous reset, active-low
- cfg_we  in  1  configuration write strobe
- cfg_pattern  in  PAT_MAX  pattern; bit 0 is the newest bit, so bit len-1 is compared against the oldest bit
- cfg_len  in  4  pattern length; legal range 1..PAT_MAX
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_err  out  1  one-cycle pulse when a config write is rejected
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  WORD_W  input word
- clr_cnt  in  1  synchronous clear of match_cnt
- z  out  1  registered match pulse
- busy  out  1  serialization in progress
- match_cnt  out  CNT_W  saturating count of matches

## Operation
- **Reset values:** state IDLE, in_ready=1, busy=0, z=0, cfg_err=0, match_cnt=0, history empty.
- **Reset config:** pattern=4'b1111 (zero-extended), len=4, overlap=0.
- **FSM states:**
  - IDLE: in_ready=1, busy=0.
  - SHIFT: busy=1; the bit index counts 0..WORD_W-1.
- **Transitions:**
  - IDLE → SHIFT on a handshake (in_valid && in_ready). The word is loaded and the index is set to 0.
  - SHIFT, index < WORD_W-1 → SHIFT, index+1.
  - SHIFT, index == WORD_W-1: on a handshake, stay in SHIFT with the new word loaded and index 0. With no handshake, go to IDLE.
- **in_ready** = (state==IDLE) || (state==SHIFT && index==WORD_W-1). This gives gapless back-to-back words.
- **Bit processing:** each SHIFT cycle, the current MSB goes into the history shift register. The fill count increments and saturates at PAT_MAX.
- **Match condition:** fill ≥ len and history[len-1:0] == pattern[len-1:0], evaluated on the updated history.
- **After a match in non-overlap mode:** fill is cleared to 0 at that edge.
- **After a match in overlap mode:** fill is kept.
- **Word boundaries:** history persists across words and across IDLE gaps.
- **Config writes:**
  - Accepted only when state==IDLE and there is no handshake in the same cycle.
  - An accepted write updates pattern, len and overlap, and clears history and fill.
  - A write is rejected when the block is not idle, or when cfg_len==0 or cfg_len>PAT_MAX.
  - A rejected write pulses cfg_err for one cycle and leaves the old config unchanged.
- **Counter:** match_cnt increments on each match and saturates at all-ones.
  - clr_cnt has priority over an increment in the same cycle; the result is 0.

## Timing
- **Bit schedule:** a word accepted at edge k has bit WORD_W-1 processed at edge k+1 and bit 0 at edge k+WORD_W.
- **Match latency:** z is high for exactly the one cycle following the edge that processed the completing bit.
- **Counter latency:** match_cnt updates on that same edge.
- **Throughput:** one word per WORD_W cycles when in_valid is held high; busy stays high continuously.
- **Reset mid-word:** the word is dropped, no z pulse follows, and all outputs return to their reset values immediately.
- **in_valid while in_ready=0:** the producer must hold the word; the block ignores it until in_ready=1.

## Structure
- **Package seq_det_pkg:**
  - state enum {IDLE, SHIFT}
  - defaults DEF_PATTERN=8'h0F, DEF_LEN=4, DEF_OVERLAP=0
- **Sub-module seq_match_core:** history register, fill counter, length-masked compare and overlap/non-overlap fill clear.
  - Inputs: bit_vld, bit, pattern, len, overlap, flush.
  - Output: combinational match.
  - The top level owns the FSM, handshake, config checking, z register and counter.

## Test plan
- Default config, one word 0xFF → z pulses after bit 4 and bit 8 (edges k+4, k+8); match_cnt=2; busy high for 8 cycles.
- Config overlap=1 while idle, then word 0xFF → 5 z pulses (edges k+4..k+8); match_cnt=5.
- Config pattern=3'b101, len=3, overlap=1, then word 0xAA → matches at bits 3, 5, 7 (edges k+3, k+5, k+7); match_cnt=3.
- Default config, back-to-back words 0x0F and 0xF0 with in_valid held → in_ready high only on edges k and k+8; 16 busy cycles with no gap; z at edges k+8 and k+12.
- cfg_we during SHIFT, and cfg_len=0 while idle → cfg_err pulses each time; subsequent 0xFF still yields 2 matches under the old config.
- Assert rst low at edge k+3 of a 0xFF word → z=0, busy=0, in_ready=1, match_cnt=0 immediately. Separately, preload the counter to all-ones and send a match → the counter stays at all-ones; clr_cnt together with a match gives 0.
